// File: rtl/tt_chk_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
package tt_chk_pkg;

  // 2-bit state encodings, kept as named constants so the enum values are pinned.
  localparam logic [1:0] StIdleEnc   = 2'b00;
  localparam logic [1:0] StDriveEnc  = 2'b01;
  localparam logic [1:0] StSampleEnc = 2'b10;
  localparam logic [1:0] StDoneEnc   = 2'b11;

  typedef enum logic [1:0] {
    StIdle   = StIdleEnc,
    StDrive  = StDriveEnc,
    StSample = StSampleEnc,
    StDone   = StDoneEnc
  } state_e;

  // Number of input vectors swept for an n_in-input function.
  function automatic int unsigned n_vec(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter with a zero flag; paces how long each vector is held.
module tt_settle_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps every input vector of a small combinational block and checks each
// response against a truth table, collecting a per-vector error mask.
module tt_sweep_checker
  import tt_chk_pkg::*;
#(
  parameter int unsigned N_IN     = 3,
  parameter              EXPECTED = 8'hBB,
  parameter int          SETTLE   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_IN-1:0]      vec_o,
  input  logic                 resp_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   err_mask,
  output logic [N_IN:0]        err_count
);

  localparam int unsigned NVec = n_vec(N_IN);
  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [NVec-1:0] ExpTt = EXPECTED;
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE - 1);

  if (SETTLE < 1) begin : g_bad_settle
    $error("tt_sweep_checker: SETTLE must be at least 1");
  end
  if ($bits(EXPECTED) != NVec) begin : g_bad_expected
    $error("tt_sweep_checker: EXPECTED width must equal 2**N_IN");
  end

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [NVec-1:0]   mask_q, mask_d;
  logic [N_IN:0]     errc_q, errc_d;
  logic              tmr_load, tmr_dec, tmr_zero;

  tt_settle_timer #(
    .Width(CntW)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (tmr_load),
    .load_val_i (SettleLoad),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // State, vector and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= '0;
      mask_q  <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      errc_q  <= errc_d;
    end
  end

  // Next-state logic: start is only seen in IDLE/DONE, so it is ignored mid-sweep.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    mask_d   = mask_q;
    errc_d   = errc_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          mask_d   = '0;
          errc_d   = '0;
          vec_d    = '0;
          tmr_load = 1'b1;
          state_d  = StDrive;
        end
      end
      StDrive: begin
        if (tmr_zero) begin
          state_d = StSample;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      StSample: begin
        if (resp_i != ExpTt[vec_q]) begin
          mask_d[vec_q] = 1'b1;
          errc_d        = errc_q + 1'b1;
        end
        // Last vector is kept on vec_o once the sweep is done.
        if (vec_q == '1) begin
          state_d = StDone;
        end else begin
          vec_d    = vec_q + 1'b1;
          tmr_load = 1'b1;
          state_d  = StDrive;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decode directly from registered state.
  always_comb begin
    busy      = (state_q == StDrive) || (state_q == StSample);
    done      = (state_q == StDone);
    pass      = (state_q == StDone) && (errc_q == '0);
    vec_o     = vec_q;
    err_mask  = mask_q;
    err_count = errc_q;
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker with an inline model of the checked function.
module tb_tt_sweep_checker;

  localparam logic [7:0] TT = 8'hBB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start2;
  logic [2:0] vec1, vec2;
  logic       resp1, resp2;
  logic       busy1, busy2, done1, done2, pass1, pass2;
  logic [7:0] mask1, mask2;
  logic [3:0] cnt1, cnt2;

  // 0 = correct function, 1 = stuck 0, 2 = stuck 1, 3 = slow (wrong for first 2 cycles)
  int mode1 = 0, mode2 = 0;
  int age1 = 0, age2 = 0, held1, held2;
  logic [2:0] prev1 = 3'd0, prev2 = 3'd0;

  int n_cmp = 0, n_bad = 0;
  int n;
  bit pulsed;

  always #5 clk = ~clk;

  tt_sweep_checker #(.N_IN(3), .EXPECTED(8'hBB), .SETTLE(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .vec_o(vec1), .resp_i(resp1),
    .busy(busy1), .done(done1), .pass(pass1), .err_mask(mask1), .err_count(cnt1)
  );

  tt_sweep_checker #(.N_IN(3), .EXPECTED(8'hBB), .SETTLE(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .vec_o(vec2), .resp_i(resp2),
    .busy(busy2), .done(done2), .pass(pass2), .err_mask(mask2), .err_count(cnt2)
  );

  function automatic logic model(input int mode, input logic [2:0] v, input int held);
    logic [7:0] t;
    logic       f;
    t = TT;
    f = t[v];
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return (held > 2) ? f : ~f;
      default: return f;
    endcase
  endfunction

  // held = cycles the current vector has been on vec_o, counting this one.
  always_comb begin
    held1 = (vec1 != prev1) ? 1 : age1 + 1;
    held2 = (vec2 != prev2) ? 1 : age2 + 1;
    resp1 = model(mode1, vec1, held1);
    resp2 = model(mode2, vec2, held2);
  end

  always @(posedge clk) begin
    prev1 <= vec1;
    prev2 <= vec2;
    age1  <= (held1 > 100) ? 100 : held1;
    age2  <= (held2 > 100) ? 100 : held2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start and return how many edges until done (edge sampling start = 1).
  task automatic sweep1(output int cyc);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  task automatic sweep2(output int cyc);
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    cyc = 1;
    while (!done2 && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    #23;
    check("reset_outs1", {vec1, busy1, done1, pass1, mask1, cnt1}, 32'd0);
    check("reset_outs2", {vec2, busy2, done2, pass2, mask2, cnt2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    check("idle_after_release", {busy1, done1}, 32'd0);

    // 1: good function, vector stepping and latency
    mode1  = 0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("t1_busy", busy1, 1);
    for (int k = 1; k <= 24; k++) begin
      check($sformatf("t1_vec_k%0d", k), vec1, (k - 1) / 3);
      if (k == 24) check("t1_not_done_24", done1, 0);
      else step();
    end
    step();
    check("t1_done_25", done1, 1);
    check("t1_busy_low", busy1, 0);
    check("t1_pass", pass1, 1);
    check("t1_mask", mask1, 8'h00);
    check("t1_count", cnt1, 0);
    check("t1_last_vec", vec1, 7);

    // 2: stuck at 0
    mode1 = 1;
    sweep1(n);
    check("t2_latency", n, 25);
    check("t2_mask", mask1, 8'hBB);
    check("t2_count", cnt1, 6);
    check("t2_pass", pass1, 0);

    // 3: stuck at 1
    mode1 = 2;
    sweep1(n);
    check("t3_latency", n, 25);
    check("t3_mask", mask1, 8'h44);
    check("t3_count", cnt1, 2);
    check("t3_pass", pass1, 0);

    // 4: start while busy is ignored; next start clears previous results
    mode1  = 1;
    pulsed = 1'b0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    n = 1;
    while (!done1 && n < 100) begin
      if (vec1 == 3'd3 && !pulsed) begin
        start1 = 1'b1;
        pulsed = 1'b1;
      end else begin
        start1 = 1'b0;
      end
      step();
      n++;
    end
    start1 = 1'b0;
    check("t4_pulsed", pulsed, 1);
    check("t4_latency", n, 25);
    check("t4_mask", mask1, 8'hBB);
    check("t4_count", cnt1, 6);
    mode1  = 0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("t4_done_cleared", done1, 0);
    check("t4_mask_cleared", mask1, 8'h00);
    check("t4_count_cleared", cnt1, 0);
    check("t4_vec_restart", vec1, 0);
    check("t4_busy", busy1, 1);
    n = 1;
    while (!done1 && n < 100) begin
      step();
      n++;
    end
    check("t4_latency2", n, 25);
    check("t4_pass2", pass1, 1);

    // 5: asynchronous reset mid-sweep
    mode1  = 1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    n = 1;
    while (vec1 != 3'd5 && n < 100) begin
      step();
      n++;
    end
    check("t5_reached_vec5", vec1, 5);
    check("t5_partial_mask", mask1 != 8'h00, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_outs", {vec1, busy1, done1, pass1, mask1, cnt1}, 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    step();
    check("t5_idle_after", {vec1, busy1, done1, pass1, mask1, cnt1}, 32'd0);
    mode1 = 0;
    sweep1(n);
    check("t5_latency", n, 25);
    check("t5_pass", pass1, 1);

    // 6: SETTLE=1 instance, then slow-responding function
    mode2 = 0;
    sweep2(n);
    check("t6_latency", n, 17);
    check("t6_pass", pass2, 1);
    check("t6_mask", mask2, 8'h00);
    mode2 = 3;
    sweep2(n);
    check("t6_slow_latency", n, 17);
    check("t6_slow_any_err", mask2 != 8'h00, 1);
    check("t6_slow_mask", mask2, 8'hFF);
    check("t6_slow_count", cnt2, 8);
    check("t6_slow_pass", pass2, 0);
    mode1 = 3;
    sweep1(n);
    check("t6_slow_settle2_latency", n, 25);
    check("t6_slow_settle2_pass", pass1, 1);
    check("t6_slow_settle2_mask", mask1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
